// File: rtl/robo_pkg.sv
// Shared definitions for the robot wheel actuator: FSM state encoding,
// H-bridge drive codes {esq_fwd, esq_rev, dir_fwd, dir_rev} and timer width.
package robo_pkg;

    typedef enum logic [1:0] {
        OCIOSO    = 2'b00,
        AVANCANDO = 2'b01,
        GIRANDO   = 2'b10,
        PAUSA     = 2'b11
    } estado_t;

    localparam logic [3:0] PARADO  = 4'b0000;
    localparam logic [3:0] FRENTE  = 4'b1010;
    localparam logic [3:0] DIREITA = 4'b1001;

    localparam int W_TEMP = 8;

endpackage

// File: rtl/robo_temporizador.sv
// Loadable down-counter shared by every timed state of the actuator;
// zero is high while the count sits at 0 and the counter holds there.
module robo_temporizador
    import robo_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              carga,
    input  logic [W_TEMP-1:0] valor,
    output logic              zero
);

    logic [W_TEMP-1:0] conta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conta <= '0;
        end else if (carga) begin
            conta <= valor;
        end else if (conta != '0) begin
            conta <= conta - 1'b1;
        end
    end

    assign zero = (conta == '0);

endmodule

// File: rtl/robo_atuador.sv
// Turns avancar/girar level commands into timed H-bridge drive with a dead-time
// after every motion. Odometry counters exist only when ROBO_ODOMETRIA_EN is defined.
module robo_atuador
    import robo_pkg::*;
#(
    parameter int T_AVANCO = 16,
    parameter int T_GIRO   = 24,
    parameter int T_PAUSA  = 2,
    parameter int W_CONT   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              avancar,
    input  logic              girar,
    output logic              esq_fwd,
    output logic              esq_rev,
    output logic              dir_fwd,
    output logic              dir_rev,
    output logic              ocupado,
    output logic              fim,
    output logic              erro,
    output logic [W_CONT-1:0] passos,
    output logic [W_CONT-1:0] giros
);

    // Timer loads are duration-1 because the zero cycle itself is part of the state.
    localparam logic [W_TEMP-1:0] CARGA_AV = W_TEMP'(T_AVANCO - 1);
    localparam logic [W_TEMP-1:0] CARGA_GI = W_TEMP'(T_GIRO - 1);
    localparam logic [W_TEMP-1:0] CARGA_PA = W_TEMP'(T_PAUSA - 1);

    estado_t           estado;
    estado_t           estado_prox;
    logic [3:0]        rodas;
    logic [3:0]        rodas_prox;
    logic              ocupado_prox;
    logic              fim_prox;
    logic              erro_prox;
    logic              carga;
    logic [W_TEMP-1:0] valor;
    logic              zero;

    robo_temporizador u_temporizador (
        .clock (clock),
        .reset (reset),
        .carga (carga),
        .valor (valor),
        .zero  (zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado  <= OCIOSO;
            rodas   <= PARADO;
            ocupado <= 1'b0;
            fim     <= 1'b0;
            erro    <= 1'b0;
        end else begin
            estado  <= estado_prox;
            rodas   <= rodas_prox;
            ocupado <= ocupado_prox;
            fim     <= fim_prox;
            erro    <= erro_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        carga       = 1'b0;
        valor       = '0;
        fim_prox    = 1'b0;
        erro_prox   = erro;
        case (estado)
            OCIOSO: begin
                if (avancar && girar) begin
                    erro_prox = 1'b1;
                end else if (avancar) begin
                    estado_prox = AVANCANDO;
                    carga       = 1'b1;
                    valor       = CARGA_AV;
                end else if (girar) begin
                    estado_prox = GIRANDO;
                    carga       = 1'b1;
                    valor       = CARGA_GI;
                end
            end
            AVANCANDO, GIRANDO: begin
                if (zero) begin
                    estado_prox = PAUSA;
                    carga       = 1'b1;
                    valor       = CARGA_PA;
                    fim_prox    = 1'b1;
                end
            end
            PAUSA: begin
                if (zero) begin
                    estado_prox = OCIOSO;
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        rodas_prox   = PARADO;
        ocupado_prox = (estado_prox != OCIOSO);
        case (estado_prox)
            AVANCANDO: rodas_prox = FRENTE;
            GIRANDO:   rodas_prox = DIREITA;
            default:   rodas_prox = PARADO;
        endcase
    end

    assign {esq_fwd, esq_rev, dir_fwd, dir_rev} = rodas;

`ifdef ROBO_ODOMETRIA_EN
    function automatic logic [W_CONT-1:0] sat_inc(input logic [W_CONT-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic fim_passo;
    logic fim_giro;

    assign fim_passo = (estado == AVANCANDO) && zero;
    assign fim_giro  = (estado == GIRANDO) && zero;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            passos <= '0;
            giros  <= '0;
        end else begin
            if (fim_passo) passos <= sat_inc(passos);
            if (fim_giro)  giros  <= sat_inc(giros);
        end
    end
`else
    assign passos = '0;
    assign giros  = '0;
`endif

endmodule

// File: tb/tb_robo_atuador.sv
// Scoreboard bench for robo_atuador: stimulus queues the expected motion records,
// a negedge monitor checks each record when fim pulses.
module tb_robo_atuador;

`ifdef ROBO_ODOMETRIA_EN
    localparam bit ODOM = 1'b1;
`else
    localparam bit ODOM = 1'b0;
`endif

    localparam logic [3:0] C_PARADO  = 4'b0000;
    localparam logic [3:0] C_FRENTE  = 4'b1010;
    localparam logic [3:0] C_DIREITA = 4'b1001;
    localparam int T_PAUSA_TB = 2;

    logic clock = 1'b0;
    logic reset;
    logic avancar, girar;
    logic esq_fwd, esq_rev, dir_fwd, dir_rev, ocupado, fim, erro;
    logic [15:0] passos, giros;

    logic av2;
    logic zero2;
    logic ef2, er2, df2, dr2, oc2, fim2, erro2;
    logic [1:0] passos2, giros2;

    always #5 clock = ~clock;

    robo_atuador dut (
        .clock(clock), .reset(reset), .avancar(avancar), .girar(girar),
        .esq_fwd(esq_fwd), .esq_rev(esq_rev), .dir_fwd(dir_fwd), .dir_rev(dir_rev),
        .ocupado(ocupado), .fim(fim), .erro(erro), .passos(passos), .giros(giros)
    );

    assign zero2 = 1'b0;

    robo_atuador #(.T_AVANCO(2), .T_GIRO(2), .T_PAUSA(1), .W_CONT(2)) dut_sat (
        .clock(clock), .reset(reset), .avancar(av2), .girar(zero2),
        .esq_fwd(ef2), .esq_rev(er2), .dir_fwd(df2), .dir_rev(dr2),
        .ocupado(oc2), .fim(fim2), .erro(erro2), .passos(passos2), .giros(giros2)
    );

    typedef struct {
        logic [3:0] code;
        int         len;
        int         passos;
        int         giros;
        logic       erro;
        int         gap;
    } exp_t;

    exp_t q[$];
    int applied = 0;
    int miscompares = 0;

    task automatic chk(input string nome, input longint act, input longint exp);
        applied++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, act, exp, $time);
        end
    endtask

    function automatic int ex(input int n);
        return ODOM ? n : 0;
    endfunction

    task automatic push(input logic [3:0] code, input int len, input int p, input int g,
                        input logic e, input int gap);
        exp_t it;
        it.code = code; it.len = len; it.passos = p; it.giros = g; it.erro = e; it.gap = gap;
        q.push_back(it);
    endtask

    task automatic wait_idle(input string nome);
        int n;
        n = 0;
        while (ocupado && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 200) chk({nome, "_timeout"}, 1, 0);
    endtask

    // Monitor: run-length of the wheel code, fim-to-fim gap and dead-time length.
    logic [3:0] cur_code = 4'b0, prv_code = 4'b0, c;
    int run = 0, prv_len = 0, cyc = 0, last_fim = 0, plen = 0;
    bit in_pausa = 1'b0;

    always @(negedge clock) begin
        exp_t e;
        c = {esq_fwd, esq_rev, dir_fwd, dir_rev};
        cyc++;
        if ((esq_fwd && esq_rev) || (dir_fwd && dir_rev) || esq_rev) begin
            miscompares++;
            $display("FAIL wheel_invariant: got %b, expected no fwd/rev overlap and esq_rev=0", c);
        end
        if (c != C_PARADO && !ocupado) begin
            miscompares++;
            $display("FAIL ocupado_drive: got ocupado=0 with drive %b, expected 1", c);
        end
        if (c == cur_code) run++;
        else begin
            prv_code = cur_code; prv_len = run; cur_code = c; run = 1;
        end
        if (in_pausa) begin
            if (ocupado && c == C_PARADO) plen++;
            else begin
                chk("pausa_len", plen, T_PAUSA_TB);
                in_pausa = 1'b0;
            end
        end
        if (fim) begin
            if (q.size() == 0) begin
                chk("unexpected_fim", 1, 0);
            end else begin
                e = q.pop_front();
                chk("drive_code", prv_code, e.code);
                chk("drive_len", prv_len, e.len);
                chk("fim_in_pausa", c, C_PARADO);
                chk("passos", passos, e.passos);
                chk("giros", giros, e.giros);
                chk("erro", erro, e.erro);
                if (e.gap >= 0) chk("period", cyc - last_fim, e.gap);
            end
            in_pausa = 1'b1;
            plen = 1;
            last_fim = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; avancar = 1'b0; girar = 1'b0; av2 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_rodas", {esq_fwd, esq_rev, dir_fwd, dir_rev}, C_PARADO);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_fim", fim, 0);
        chk("rst_erro", erro, 0);
        chk("rst_passos", passos, 0);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("idle_ocupado", ocupado, 0);

        // Single forward step.
        push(C_FRENTE, 16, ex(1), 0, 1'b0, -1);
        avancar = 1'b1;
        @(posedge clock); #1;
        avancar = 1'b0;
        chk("fwd_latency", {esq_fwd, esq_rev, dir_fwd, dir_rev}, C_FRENTE);
        wait_idle("fwd");

        // Held rotation: three back-to-back motions, 27-cycle period.
        push(C_DIREITA, 24, ex(1), ex(1), 1'b0, -1);
        push(C_DIREITA, 24, ex(1), ex(2), 1'b0, 27);
        push(C_DIREITA, 24, ex(1), ex(3), 1'b0, 27);
        girar = 1'b1;
        repeat (59) @(posedge clock);
        #1;
        girar = 1'b0;
        wait_idle("rot");

        // Illegal command, then a legal step with erro still set.
        avancar = 1'b1; girar = 1'b1;
        @(posedge clock); #1;
        avancar = 1'b0; girar = 1'b0;
        chk("ilegal_erro", erro, 1);
        chk("ilegal_ocupado", ocupado, 0);
        chk("ilegal_rodas", {esq_fwd, esq_rev, dir_fwd, dir_rev}, C_PARADO);
        repeat (3) @(posedge clock);
        #1;
        chk("ilegal_ocioso", ocupado, 0);
        push(C_FRENTE, 16, ex(2), ex(3), 1'b1, -1);
        avancar = 1'b1;
        @(posedge clock); #1;
        avancar = 1'b0;
        wait_idle("pos_ilegal");

        // Command switched mid-forward: forward completes, then rotation.
        push(C_FRENTE, 16, ex(3), ex(3), 1'b1, -1);
        push(C_DIREITA, 24, ex(3), ex(4), 1'b1, 27);
        avancar = 1'b1;
        @(posedge clock);
        repeat (5) @(posedge clock);
        #1;
        avancar = 1'b0; girar = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        girar = 1'b0;
        wait_idle("troca");

        // Saturation on the 2-bit instance: five 4-cycle steps.
        av2 = 1'b1;
        repeat (12) @(posedge clock);
        #1;
        chk("sat_passos3", passos2, ex(3));
        repeat (6) @(posedge clock);
        #1;
        av2 = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        chk("sat_passos5", passos2, ex(3));
        chk("sat_giros", giros2, 0);
        chk("sat_ocupado", oc2, 0);

        // Asynchronous reset in the middle of a rotation.
        girar = 1'b1;
        @(posedge clock); #1;
        girar = 1'b0;
        repeat (8) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_rodas", {esq_fwd, esq_rev, dir_fwd, dir_rev}, C_PARADO);
        chk("arst_ocupado", ocupado, 0);
        chk("arst_fim", fim, 0);
        chk("arst_erro", erro, 0);
        chk("arst_passos", passos, 0);
        chk("arst_giros", giros, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("pos_rst_ocupado", ocupado, 0);
        chk("pos_rst_rodas", {esq_fwd, esq_rev, dir_fwd, dir_rev}, C_PARADO);
        chk("fila_vazia", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
